// File: rtl/alu_seq_loader_if.sv
// Operator-facing bus of the operand loader / ALU: switch inputs in, result and flags out.
// master drives the switches (board or bench), slave is the loader itself.
interface alu_seq_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_IN   = 8
);
  logic [NB_IN-1:0]   i_dato;
  logic [1:0]         i_sw;
  logic               i_mode;
  logic               i_load;
  logic               i_clear;
  logic [NB_DATA-1:0] o_result;
  logic               o_zero;
  logic               o_carry;
  logic               o_ovf;
  logic               o_err;
  logic               o_valid;
  logic [1:0]         o_state;

  modport master (
    output i_dato, i_sw, i_mode, i_load, i_clear,
    input  o_result, o_zero, o_carry, o_ovf, o_err, o_valid, o_state
  );

  modport slave (
    input  i_dato, i_sw, i_mode, i_load, i_clear,
    output o_result, o_zero, o_carry, o_ovf, o_err, o_valid, o_state
  );
endinterface

// File: rtl/alu_seq_loader.sv
// Captures A, B and opcode from a shared switch bus on load-button edges (manual or
// auto-advancing), then executes once and registers the result with status flags.
module alu_seq_loader #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_IN   = 8
) (
  input  logic              clk,
  input  logic              i_rst_n,
  alu_seq_loader_if.slave   bus
);

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_OP   = 2'b10;
  localparam logic [1:0] S_EXEC = 2'b11;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] a_reg, b_reg, result_reg;
  logic [NB_OP-1:0]   op_reg;
  logic [1:0]         state_reg;
  logic               load_q_reg, mode_q_reg;
  logic               zero_reg, carry_reg, ovf_reg, err_reg, valid_reg;

  logic               ld, mode_chg;
  logic [NB_DATA:0]   sum_ext, diff_ext;
  logic               shift_big;
  logic [NB_DATA-1:0] srl_val, sra_val;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_carry, alu_ovf, alu_err, alu_zero;

  assign ld       = bus.i_load & ~load_q_reg;
  assign mode_chg = bus.i_mode ^ mode_q_reg;

  assign sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff_ext = {1'b0, a_reg} - {1'b0, b_reg};

  // NB_DATA always fits in NB_DATA bits (n < 2**n), so the compare stays at operand width.
  assign shift_big = (b_reg >= NB_DATA'(NB_DATA));
  assign srl_val   = shift_big ? '0 : (a_reg >> b_reg);
  assign sra_val   = shift_big ? {NB_DATA{a_reg[MSB]}} : $unsigned($signed(a_reg) >>> b_reg);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_res   = sum_ext[MSB:0];
        alu_carry = sum_ext[NB_DATA];
        alu_ovf   = (a_reg[MSB] == b_reg[MSB]) && (sum_ext[MSB] != a_reg[MSB]);
      end
      OP_SUB: begin
        // The extra bit of the widened difference is exactly the unsigned borrow (A < B).
        alu_res   = diff_ext[MSB:0];
        alu_carry = diff_ext[NB_DATA];
        alu_ovf   = (a_reg[MSB] != b_reg[MSB]) && (diff_ext[MSB] != a_reg[MSB]);
      end
      OP_AND:  alu_res = a_reg & b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      OP_XOR:  alu_res = a_reg ^ b_reg;
      OP_NOR:  alu_res = ~(a_reg | b_reg);
      OP_SRA:  alu_res = sra_val;
      OP_SRL:  alu_res = srl_val;
      default: alu_err = 1'b1;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      state_reg  <= S_A;
      load_q_reg <= 1'b0;
      mode_q_reg <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      load_q_reg <= bus.i_load;
      mode_q_reg <= bus.i_mode;
      valid_reg  <= 1'b0;
      if (bus.i_clear) begin
        a_reg      <= '0;
        b_reg      <= '0;
        op_reg     <= '0;
        result_reg <= '0;
        zero_reg   <= 1'b0;
        carry_reg  <= 1'b0;
        ovf_reg    <= 1'b0;
        err_reg    <= 1'b0;
        state_reg  <= S_A;
      end else if (state_reg == S_EXEC) begin
        result_reg <= alu_res;
        zero_reg   <= alu_zero;
        carry_reg  <= alu_carry;
        ovf_reg    <= alu_ovf;
        err_reg    <= alu_err;
        valid_reg  <= 1'b1;
        state_reg  <= S_A;
      end else if (mode_chg) begin
        // Switching mode mid-sequence restarts the sequence; operands are kept.
        state_reg <= S_A;
      end else if (ld) begin
        if (!bus.i_mode) begin
          case (bus.i_sw)
            2'b00: begin
              a_reg     <= bus.i_dato[NB_DATA-1:0];
              state_reg <= S_A;
            end
            2'b01: begin
              b_reg     <= bus.i_dato[NB_DATA-1:0];
              state_reg <= S_A;
            end
            2'b10: begin
              op_reg    <= bus.i_dato[NB_OP-1:0];
              state_reg <= S_EXEC;
            end
            default: ;
          endcase
        end else begin
          case (state_reg)
            S_A: begin
              a_reg     <= bus.i_dato[NB_DATA-1:0];
              state_reg <= S_B;
            end
            S_B: begin
              b_reg     <= bus.i_dato[NB_DATA-1:0];
              state_reg <= S_OP;
            end
            S_OP: begin
              op_reg    <= bus.i_dato[NB_OP-1:0];
              state_reg <= S_EXEC;
            end
            default: state_reg <= S_A;
          endcase
        end
      end
    end
  end

  assign bus.o_result = result_reg;
  assign bus.o_zero   = zero_reg;
  assign bus.o_carry  = carry_reg;
  assign bus.o_ovf    = ovf_reg;
  assign bus.o_err    = err_reg;
  assign bus.o_valid  = valid_reg;
  assign bus.o_state  = state_reg;

endmodule

// File: tb/tb_alu_seq_loader.sv
// Directed scenarios plus randomized switch activity, checked every cycle against an
// integer-arithmetic model of the loader and ALU.
module tb_alu_seq_loader;
  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int MASK = FULL - 1;

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_loader_if #(.NB_DATA(W), .NB_OP(6), .NB_IN(8)) bus ();

  alu_seq_loader #(.NB_DATA(W), .NB_OP(6), .NB_IN(8)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic.
  function automatic void alu_model(input int a, input int b, input int op,
                                    output int r, output int z, output int c,
                                    output int v, output int e);
    int sa, sb, s;
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      'h20: begin
        r = (a + b) & MASK; c = (a + b >= FULL);
        s = sa + sb; v = (s >= HALF || s < -HALF);
      end
      'h22: begin
        r = (a - b + FULL) & MASK; c = (a < b);
        s = sa - sb; v = (s >= HALF || s < -HALF);
      end
      'h24: r = a & b;
      'h25: r = a | b;
      'h26: r = a ^ b;
      'h27: r = ~(a | b) & MASK;
      'h03: r = (b >= W) ? ((sa < 0) ? MASK : 0) : ((sa >>> b) & MASK);
      'h02: r = (b >= W) ? 0 : (a >> b);
      default: e = 1;
    endcase
    z = (r == 0);
  endfunction

  // Model state: operands, position in the load sequence (0=A,1=B,2=OP,3=exec), outputs.
  int m_a, m_b, m_op, m_ph;
  int m_res, m_z, m_c, m_v, m_e, m_valid;
  int m_lq, m_mq;
  int m_ld, m_mchg;

  always @(posedge clk) begin
    if (!i_rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_ph = 0;
      m_res = 0; m_z = 0; m_c = 0; m_v = 0; m_e = 0; m_valid = 0;
      m_lq = 0; m_mq = 0;
    end else begin
      m_ld   = (bus.i_load && !m_lq) ? 1 : 0;
      m_mchg = (int'(bus.i_mode) != m_mq) ? 1 : 0;
      m_valid = 0;
      if (bus.i_clear) begin
        m_a = 0; m_b = 0; m_op = 0; m_ph = 0;
        m_res = 0; m_z = 0; m_c = 0; m_v = 0; m_e = 0;
      end else if (m_ph == 3) begin
        alu_model(m_a, m_b, m_op, m_res, m_z, m_c, m_v, m_e);
        m_valid = 1;
        m_ph = 0;
        $display("exec a=%02h b=%02h op=%02h -> result=%02h z=%0d c=%0d v=%0d err=%0d",
                 m_a, m_b, m_op, m_res, m_z, m_c, m_v, m_e);
      end else if (m_mchg != 0) begin
        m_ph = 0;
      end else if (m_ld != 0) begin
        if (!bus.i_mode) begin
          if (bus.i_sw == 2'd0) m_a = int'(bus.i_dato);
          else if (bus.i_sw == 2'd1) m_b = int'(bus.i_dato);
          else if (bus.i_sw == 2'd2) begin m_op = int'(bus.i_dato) & 'h3F; m_ph = 3; end
        end else begin
          if (m_ph == 0) m_a = int'(bus.i_dato);
          else if (m_ph == 1) m_b = int'(bus.i_dato);
          else m_op = int'(bus.i_dato) & 'h3F;
          m_ph = m_ph + 1;
        end
      end
      m_lq = int'(bus.i_load);
      m_mq = int'(bus.i_mode);
    end
  end

  // Outputs are registered, so they are meaningful on every cycle.
  always @(negedge clk) begin
    chk("result", 32'(bus.o_result), m_res);
    chk("zero",   32'(bus.o_zero),   m_z);
    chk("carry",  32'(bus.o_carry),  m_c);
    chk("ovf",    32'(bus.o_ovf),    m_v);
    chk("err",    32'(bus.o_err),    m_e);
    chk("valid",  32'(bus.o_valid),  m_valid);
    chk("state",  32'(bus.o_state),  m_ph);
  end

  task automatic ld_pulse(input logic [7:0] d, input logic [1:0] sw);
    @(negedge clk);
    bus.i_dato = d; bus.i_sw = sw; bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1;
    end
    chk({name, "_valid_seen"}, 32'(seen), 1);
  endtask

  task automatic seq_exec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input string name);
    ld_pulse(a, 2'b00);
    ld_pulse(b, 2'b00);
    ld_pulse(op, 2'b00);
    wait_valid(name);
  endtask

  initial begin
    int ops[8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h03, 'h02};
    bus.i_dato = '0; bus.i_sw = '0; bus.i_mode = 1'b0; bus.i_load = 1'b0; bus.i_clear = 1'b0;

    // Reset with a toggling button
    @(negedge clk); bus.i_load = 1'b1;
    @(negedge clk); bus.i_load = 1'b0;
    chk("rst_result", 32'(bus.o_result), 0);
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_capture_state", 32'(bus.o_state), 0);

    // Manual ADD
    ld_pulse(8'h7F, 2'b00);
    ld_pulse(8'h01, 2'b01);
    ld_pulse(8'h20, 2'b10);
    wait_valid("add");
    chk("add_result", 32'(bus.o_result), 'h80);
    chk("add_ovf", 32'(bus.o_ovf), 1);
    chk("add_carry", 32'(bus.o_carry), 0);
    chk("add_zero", 32'(bus.o_zero), 0);
    @(negedge clk);
    chk("add_valid_single", 32'(bus.o_valid), 0);

    // Sequential SUB
    bus.i_mode = 1'b1;
    repeat (2) @(negedge clk);
    ld_pulse(8'h03, 2'b11);
    chk("seq_state_b", 32'(bus.o_state), 1);
    ld_pulse(8'h05, 2'b11);
    chk("seq_state_op", 32'(bus.o_state), 2);
    ld_pulse(8'h22, 2'b11);
    chk("seq_state_exec", 32'(bus.o_state), 3);
    wait_valid("sub");
    chk("sub_result", 32'(bus.o_result), 'hFE);
    chk("sub_carry", 32'(bus.o_carry), 1);
    chk("sub_ovf", 32'(bus.o_ovf), 0);
    chk("sub_state_back", 32'(bus.o_state), 0);

    // Held button gives one capture
    @(negedge clk);
    bus.i_dato = 8'h90; bus.i_load = 1'b1;
    repeat (10) @(negedge clk);
    bus.i_load = 1'b0;
    chk("held_state", 32'(bus.o_state), 1);
    ld_pulse(8'h02, 2'b00);
    ld_pulse(8'h03, 2'b00);
    wait_valid("sra2");
    chk("sra2_result", 32'(bus.o_result), 'hE4);

    seq_exec(8'h90, 8'h09, 8'h03, "sra9");
    chk("sra9_result", 32'(bus.o_result), 'hFF);
    seq_exec(8'h90, 8'h09, 8'h02, "srl9");
    chk("srl9_result", 32'(bus.o_result), 0);
    chk("srl9_zero", 32'(bus.o_zero), 1);

    // Illegal opcode then clear mid-sequence
    seq_exec(8'h90, 8'h09, 8'h3F, "illegal");
    chk("ill_result", 32'(bus.o_result), 0);
    chk("ill_err", 32'(bus.o_err), 1);
    chk("ill_zero", 32'(bus.o_zero), 1);
    ld_pulse(8'h11, 2'b00);
    chk("pre_clear_state", 32'(bus.o_state), 1);
    @(negedge clk); bus.i_clear = 1'b1;
    @(negedge clk); bus.i_clear = 1'b0;
    chk("clr_state", 32'(bus.o_state), 0);
    chk("clr_err", 32'(bus.o_err), 0);
    chk("clr_valid", 32'(bus.o_valid), 0);
    // ADD of the cleared operands must give zero
    bus.i_mode = 1'b0;
    repeat (2) @(negedge clk);
    ld_pulse(8'h20, 2'b10);
    wait_valid("clr_add");
    chk("clr_add_result", 32'(bus.o_result), 0);
    chk("clr_add_zero", 32'(bus.o_zero), 1);
    chk("clr_add_err", 32'(bus.o_err), 0);

    // Randomized switch activity
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.i_dato = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0)
        bus.i_dato[5:0] = 6'(ops[$urandom_range(0, 7)]);
      bus.i_sw    = 2'($urandom_range(0, 3));
      bus.i_load  = ($urandom_range(0, 9) < 4);
      bus.i_clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) bus.i_mode = ~bus.i_mode;
    end
    @(negedge clk);
    bus.i_load = 1'b0; bus.i_clear = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_loader.md
Name: alu_seq_loader

Overview:
Parametrised operand loader and registered ALU for the board top level. It captures operand A, operand B and the opcode from a shared switch bus on a debounced load button edge. Loading can be manual (switch-selected target) or sequential (auto-advancing A→B→OP). It executes one cycle after the opcode is captured and drives a registered result with status flags to LEDs and downstream logic.

Parameters:
NB_DATA, 8, operand/result width (≥2)
NB_OP, 6, opcode width (fixed encoding below requires 6)
NB_IN, 8, shared input bus width; must be ≥ max(NB_DATA, NB_OP)

Ports:
clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_dato  in  NB_IN  shared data/opcode bus
i_sw  in  2  manual target select: 00 A, 01 B, 10 OP, 11 none
i_mode  in  1  0 manual, 1 sequential
i_load  in  1  load button, already debounced, level
i_clear  in  1  synchronous soft clear
o_result  out  NB_DATA  registered ALU result
o_zero  out  1  result == 0
o_carry  out  1  ADD carry-out / SUB borrow
o_ovf  out  1  signed overflow (ADD/SUB only)
o_err  out  1  illegal opcode on last execution
o_valid  out  1  one-cycle pulse, result updated
o_state  out  2  FSM state for LEDs

Behaviour:
- All state is on the posedge of clk. Reset is synchronous active-low and has priority over everything else.
- Reset values: A, B, OP, load_q, all outputs = 0; state = S_A (00).
- Load edge: load_q <= i_load every cycle; ld = i_load & ~load_q. Holding i_load produces exactly one ld.
- Operand capture takes the low bits: A/B <= i_dato[NB_DATA-1:0], OP <= i_dato[NB_OP-1:0].
- States: S_A=00, S_B=01, S_OP=10, S_EXEC=11.
- Manual mode (i_mode=0):
  - ld with i_sw=00 captures A; ld with i_sw=01 captures B. The state stays S_A.
  - ld with i_sw=10 captures OP and moves to S_EXEC.
  - i_sw=11 is ignored.
- Sequential mode: ld captures A in S_A (→S_B), B in S_B (→S_OP), OP in S_OP (→S_EXEC). i_sw is ignored.
- S_EXEC lasts one cycle and ignores ld:
  - o_result and flags are updated and o_valid=1 on that edge.
  - The next state is S_A.
  - Latency: OP capture edge k → o_valid high after edge k+1.
- Outside S_EXEC, o_valid = 0. o_result and flags hold their last values.
- An i_mode change while not in S_EXEC forces S_A on the next edge. No capture occurs in that cycle. A and B are retained.
- i_clear (below reset, above ld): clears A, B, OP, o_result, all flags and o_err; state = S_A; o_valid = 0. If asserted during S_EXEC, execution is aborted and no valid pulse is produced.
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- Arithmetic and width rules:
  - ADD/SUB are computed at NB_DATA+1 bits. carry = bit NB_DATA for ADD; for SUB, carry = 1 iff A < B unsigned.
  - ovf = signed overflow of A±B. For non-ADD/SUB ops, carry and ovf are 0.
  - Shifts use A shifted by B taken unsigned. If B ≥ NB_DATA: SRL → 0, SRA → all bits equal A's sign bit.
- Illegal opcode: o_result = 0, o_zero = 1, o_err = 1, o_valid still pulses. Any legal execution clears o_err.
- o_zero reflects the new result on every execution.

Test Plan:
- Reset: hold i_rst_n=0 for 2 clks while i_load toggles → all outputs 0, o_state=00; on release there is no spurious capture.
- Manual ADD, NB_DATA=8: load A=0x7F (sw=00), B=0x01 (sw=01), OP=100000 (sw=10) → one cycle later o_result=0x80, o_ovf=1, o_carry=0, o_zero=0, o_valid a single one-cycle pulse.
- Sequential SUB: i_mode=1, three ld pulses with i_dato=0x03, 0x05, 0x22 → o_state 00→01→10→11→00; o_result=0xFE, o_carry=1, o_ovf=0.
- Held button: i_load high for 10 cycles in sequential mode → exactly one capture; state advances S_A→S_B only.
- Shifts: A=0x90, B=0x02, SRA → 0xE4; B=0x09 SRA → 0xFF; B=0x09 SRL → 0x00 with o_zero=1.
- Illegal op 111111 → o_result=0, o_err=1, o_valid pulses. Then i_clear during S_B → A=B=0, state 00, o_err=0, no o_valid.
